spi_master_param: RTL and testbench

//  Parametrised full-duplex SPI master: shifts DATA_W bits out on mosi while capturing DATA_W bits from miso.

---
 rtl/spi_master_param.sv | 185 ++++++++++++++++++
 tb/tb_spi_master_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: any CPOL/CPHA, clk-derived sclk, NUM_SS active-low selects.
// Define SPI_LOOPBACK_EN to add the lb_en input (frame samples internal mosi instead of miso).
module spi_master_param #(
    parameter int  DATA_W    = 8,
    parameter int  NUM_SS    = 1,
    parameter int  CLK_DIV   = 2,
    parameter bit  CPOL      = 1'b0,
    parameter bit  CPHA      = 1'b1,
    parameter bit  LSB_FIRST = 1'b1,
    localparam int SS_W      = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [SS_W-1:0]   ss_sel,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              sclk,
    output logic [NUM_SS-1:0] ss_n,
    output logic              mosi,
    input  logic              miso
`ifdef SPI_LOOPBACK_EN
    ,
    input  logic              lb_en
`endif
);

    localparam int CNT_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] XFER  = 3'd2;
    localparam logic [2:0] HOLD  = 3'd3;
    localparam logic [2:0] GAP   = 3'd4;

    logic [2:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [EDGE_W-1:0] edge_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [SS_W-1:0]   sel_q;
    logic              miso_in;
    logic              ss_block;
    logic              half_done;
    logic              lead_edge;
    logic              sample_edge;
    logic              shift_edge;

`ifdef SPI_LOOPBACK_EN
    logic lb_q;
    assign miso_in  = lb_q ? mosi : miso;
    assign ss_block = lb_q;
`else
    assign miso_in  = miso;
    assign ss_block = 1'b0;
`endif

    function automatic logic head(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic [DATA_W-1:0] ins(input logic [DATA_W-1:0] v, input logic b);
        return LSB_FIRST ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
    endfunction

    always_comb begin
        half_done   = (cnt == CNT_LAST);
        lead_edge   = ~edge_cnt[0];
        sample_edge = CPHA ? ~lead_edge : lead_edge;
        // CPHA=0 has no shift on the final trailing edge: mosi keeps the last bit through HOLD
        shift_edge  = ~sample_edge & (CPHA | (edge_cnt != EDGE_LAST));
    end

    always_comb begin
        tx_ready = (state == IDLE) & rst_n;
        busy     = (state != IDLE);
        ss_n     = '1;
        // an out-of-range index shifts the single 1 out, leaving all selects deasserted
        if ((state == SETUP || state == XFER || state == HOLD) && !ss_block)
            ss_n = ~(NUM_SS'(1) << sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            sclk     <= CPOL;
            mosi     <= 1'b0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            sel_q    <= '0;
`ifdef SPI_LOOPBACK_EN
            lb_q     <= 1'b0;
`endif
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sclk <= CPOL;
                    if (tx_valid) begin
                        sel_q    <= ss_sel;
`ifdef SPI_LOOPBACK_EN
                        lb_q     <= lb_en;
`endif
                        cnt      <= '0;
                        edge_cnt <= '0;
                        state    <= SETUP;
                        if (!CPHA) begin
                            mosi  <= head(tx_data);
                            tx_sh <= adv(tx_data);
                        end else begin
                            tx_sh <= tx_data;
                        end
                    end
                end
                SETUP: begin
                    if (half_done) begin
                        cnt   <= '0;
                        state <= XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                XFER: begin
                    if (half_done) begin
                        cnt      <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (sample_edge)
                            rx_sh <= ins(rx_sh, miso_in);
                        if (shift_edge) begin
                            mosi  <= head(tx_sh);
                            tx_sh <= adv(tx_sh);
                        end
                        if (edge_cnt == EDGE_LAST)
                            state <= HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (half_done) begin
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        rx_data  <= rx_sh;
                        rx_valid <= 1'b1;
                    end
                    if (half_done) begin
                        cnt   <= '0;
                        mosi  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    sclk  <= CPOL;
                    mosi  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_param.sv
// Scoreboard bench for spi_master_param: three configurations plus behavioural SPI slave models.
module tb_spi_master_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] rx;
        logic [7:0] cap;
        int         lat;
        logic [3:0] ss;
        int         edges;
    } exp_t;

    exp_t q [3][$];

    // u0: mode 1, LSB first, NUM_SS=1
    logic [7:0] tx_data0 = '0, rx_data0;
    logic       tx_valid0 = 1'b0, tx_ready0, ss_sel0 = 1'b0, rx_valid0, busy0, sclk0, ss_n0, mosi0;
    logic       miso0 = 1'b0;
    // u1: mode 0, MSB first
    logic [7:0] tx_data1 = '0, rx_data1;
    logic       tx_valid1 = 1'b0, tx_ready1, ss_sel1 = 1'b0, rx_valid1, busy1, sclk1, ss_n1, mosi1;
    logic       miso1 = 1'b0;
    // u2: mode 1, LSB first, NUM_SS=4
    logic [7:0] tx_data2 = '0, rx_data2;
    logic       tx_valid2 = 1'b0, tx_ready2, rx_valid2, busy2, sclk2, mosi2;
    logic [1:0] ss_sel2 = '0;
    logic [3:0] ss_n2;
    logic       miso2 = 1'b0;
`ifdef SPI_LOOPBACK_EN
    logic       lb_en = 1'b0;
`endif

    spi_master_param #(.DATA_W(8), .NUM_SS(1), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0),
        .ss_sel(ss_sel0), .rx_data(rx_data0), .rx_valid(rx_valid0), .busy(busy0), .sclk(sclk0),
        .ss_n(ss_n0), .mosi(mosi0), .miso(miso0)
`ifdef SPI_LOOPBACK_EN
        , .lb_en(lb_en)
`endif
    );

    spi_master_param #(.DATA_W(8), .NUM_SS(1), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
        .ss_sel(ss_sel1), .rx_data(rx_data1), .rx_valid(rx_valid1), .busy(busy1), .sclk(sclk1),
        .ss_n(ss_n1), .mosi(mosi1), .miso(miso1)
`ifdef SPI_LOOPBACK_EN
        , .lb_en(1'b0)
`endif
    );

    spi_master_param #(.DATA_W(8), .NUM_SS(4), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b1), .LSB_FIRST(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2),
        .ss_sel(ss_sel2), .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .sclk(sclk2),
        .ss_n(ss_n2), .mosi(mosi2), .miso(miso2)
`ifdef SPI_LOOPBACK_EN
        , .lb_en(1'b0)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave model u0: mode 1, drives miso on rising sclk, captures mosi on falling sclk
    logic [7:0] s0_tx = '0, s0_cap = '0;
    int   s0_idx = 0, s0_edges = 0;
    logic s0_ss = 1'b1, s0_bq = 1'b0, s0_sq = 1'b0;
    always @(busy0 or sclk0) begin
        if (busy0 === 1'b1 && s0_bq !== 1'b1) begin
            s0_idx = 0; s0_edges = 0; s0_cap = '0;
        end
        s0_bq = busy0;
        if (sclk0 !== s0_sq) begin
            s0_edges++;
            if (sclk0 === 1'b1) begin
                if (s0_idx < 8) miso0 = s0_tx[s0_idx[2:0]];
                s0_idx++;
                s0_ss = ss_n0;
            end else begin
                s0_cap = {mosi0, s0_cap[7:1]};
            end
        end
        s0_sq = sclk0;
    end

    // Slave model u1: mode 0 MSB first, first bit ready at frame start, next bits on falling sclk
    logic [7:0] s1_tx = '0, s1_cap = '0;
    int   s1_idx = 0, s1_rise = 0;
    logic s1_ss = 1'b1, s1_bq = 1'b0, s1_sq = 1'b0;
    always @(busy1 or sclk1) begin
        if (busy1 === 1'b1 && s1_bq !== 1'b1) begin
            s1_idx = 1; s1_rise = 0; s1_cap = '0;
            miso1 = s1_tx[7];
        end
        s1_bq = busy1;
        if (sclk1 !== s1_sq) begin
            if (sclk1 === 1'b1) begin
                s1_cap = {s1_cap[6:0], mosi1};
                s1_rise++;
                s1_ss = ss_n1;
            end else begin
                if (s1_idx < 8) miso1 = s1_tx[3'(7 - s1_idx)];
                s1_idx++;
            end
        end
        s1_sq = sclk1;
    end

    // Slave model u2: mode 1 LSB first, response reloaded per frame
    logic [7:0] s2_resp [2];
    logic [7:0] s2_tx = '0, s2_cap = '0;
    int   s2_idx = 0, s2_edges = 0, s2_frame = 0;
    logic [3:0] s2_ss = '1;
    logic s2_bq = 1'b0, s2_sq = 1'b0;
    always @(busy2 or sclk2) begin
        if (busy2 === 1'b1 && s2_bq !== 1'b1) begin
            s2_idx = 0; s2_edges = 0; s2_cap = '0;
            s2_tx = s2_resp[s2_frame[0]];
            s2_frame++;
        end
        s2_bq = busy2;
        if (sclk2 !== s2_sq) begin
            s2_edges++;
            if (sclk2 === 1'b1) begin
                if (s2_idx < 8) miso2 = s2_tx[s2_idx[2:0]];
                s2_idx++;
                s2_ss = ss_n2;
            end else begin
                s2_cap = {mosi2, s2_cap[7:1]};
            end
        end
        s2_sq = sclk2;
    end

    task automatic mon(input int id, input logic [7:0] rx, input logic [7:0] cap, input int lat,
                       input logic [3:0] ss, input int edges);
        exp_t e;
        n_tests++;
        if (q[id].size() == 0) begin
            n_fail++;
            $display("FAIL u%0d spurious_rx_valid: got rx_valid=1 rx_data=0x%0h, expected no pulse", id, rx);
        end else begin
            e = q[id].pop_front();
            check($sformatf("u%0d rx_data", id), rx, e.rx);
            check($sformatf("u%0d mosi_frame", id), cap, e.cap);
            check($sformatf("u%0d rx_latency", id), lat, e.lat);
            check($sformatf("u%0d ss_n", id), ss, e.ss);
            check($sformatf("u%0d sclk_edges", id), edges, e.edges);
        end
    endtask

    int hs0 = 0, hs1 = 0, hs2 = 0;
    int s2_run = 0, s2_gap = 0;
    always @(negedge clk) begin
        if (tx_valid0 && tx_ready0) hs0 = cyc + 1;
        if (tx_valid1 && tx_ready1) hs1 = cyc + 1;
        if (tx_valid2 && tx_ready2) hs2 = cyc + 1;
        if (rx_valid0 === 1'b1) mon(0, rx_data0, s0_cap, cyc - hs0, {3'b000, s0_ss}, s0_edges);
        if (rx_valid1 === 1'b1) mon(1, rx_data1, s1_cap, cyc - hs1, {3'b000, s1_ss}, s1_rise);
        if (rx_valid2 === 1'b1) mon(2, rx_data2, s2_cap, cyc - hs2, s2_ss, s2_edges);
        if (ss_n2 === 4'hF) s2_run++;
        else begin
            if (s2_run != 0) s2_gap = s2_run;
            s2_run = 0;
        end
    end

    function automatic logic rdy(input int id);
        case (id)
            0: return tx_ready0;
            1: return tx_ready1;
            default: return tx_ready2;
        endcase
    endfunction

    function automatic logic bsy(input int id);
        case (id)
            0: return busy0;
            1: return busy1;
            default: return busy2;
        endcase
    endfunction

    task automatic drive(input int id, input logic [7:0] d, input logic [1:0] sel, input logic v);
        case (id)
            0: begin tx_data0 = d; ss_sel0 = sel[0]; tx_valid0 = v; end
            1: begin tx_data1 = d; ss_sel1 = sel[0]; tx_valid1 = v; end
            default: begin tx_data2 = d; ss_sel2 = sel; tx_valid2 = v; end
        endcase
    endtask

    task automatic wait_accept(input int id);
        for (int k = 0; k < 100 && rdy(id) !== 1'b1; k++) @(negedge clk);
        check($sformatf("u%0d tx_ready_for_accept", id), rdy(id), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int id);
        for (int k = 0; k < 200 && bsy(id) !== 1'b0; k++) @(negedge clk);
        check($sformatf("u%0d busy_cleared", id), bsy(id), 0);
    endtask

    task automatic send(input int id, input logic [7:0] d, input logic [1:0] sel,
                        input logic [7:0] exp_rx, input logic [7:0] exp_cap, input logic [3:0] exp_ss,
                        input int exp_edges);
        exp_t e;
        e.rx = exp_rx; e.cap = exp_cap; e.lat = 37; e.ss = exp_ss; e.edges = exp_edges;
        @(negedge clk);
        q[id].push_back(e);
        drive(id, d, sel, 1'b1);
        wait_accept(id);
        drive(id, d, sel, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset tx_ready", tx_ready0, 1);
        check("reset busy", busy0, 0);
        check("reset ss_n u0", ss_n0, 1);
        check("reset ss_n u2", ss_n2, 4'hF);
        check("reset sclk", sclk0, 0);
        check("reset mosi", mosi0, 0);
        check("reset rx_valid", rx_valid0, 0);
        check("reset rx_data", rx_data0, 0);

        // Mode 1 frame, with ignored tx_valid/tx_data activity mid-frame
        s0_tx = 8'h3C;
        send(0, 8'hA5, 2'd0, 8'h3C, 8'hA5, 4'h0, 16);
        repeat (5) @(negedge clk);
        drive(0, 8'hFF, 2'd0, 1'b1);
        repeat (10) @(negedge clk);
        drive(0, 8'hFF, 2'd0, 1'b0);
        wait_idle(0);

        // Mode 0, MSB first: 8 rising edges
        s1_tx = 8'h7E;
        send(1, 8'h81, 2'd0, 8'h7E, 8'h81, 4'h0, 8);
        wait_idle(1);

        // Back-to-back on NUM_SS=4 with tx_valid held
        s2_resp[0] = 8'h34;
        s2_resp[1] = 8'h78;
        @(negedge clk);
        q[2].push_back('{rx: 8'h34, cap: 8'h12, lat: 37, ss: 4'b1011, edges: 16});
        q[2].push_back('{rx: 8'h78, cap: 8'h56, lat: 37, ss: 4'b0111, edges: 16});
        drive(2, 8'h12, 2'd2, 1'b1);
        wait_accept(2);
        drive(2, 8'h56, 2'd3, 1'b1);
        wait_accept(2);
        drive(2, 8'h00, 2'd0, 1'b0);
        wait_idle(2);
        check("u2 ss_n_gap_clks", s2_gap, 3);

        // Reset mid-frame
        s0_tx = 8'h99;
        @(negedge clk);
        drive(0, 8'hF0, 2'd0, 1'b1);
        wait_accept(0);
        drive(0, 8'hF0, 2'd0, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        check("u0 ss_n_before_abort", ss_n0, 0);
        rst_n = 1'b0;
        #1;
        check("abort ss_n", ss_n0, 1);
        check("abort sclk", sclk0, 0);
        check("abort rx_data", rx_data0, 0);
        check("abort busy", busy0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        s0_tx = 8'hC3;
        send(0, 8'h55, 2'd0, 8'hC3, 8'h55, 4'h0, 16);
        wait_idle(0);

        // Out-of-range select: frame timed, no select asserted
        s0_tx = 8'h69;
        send(0, 8'h96, 2'd1, 8'h69, 8'h96, 4'h1, 16);
        wait_idle(0);
        check("u0 tx_ready_after_gap", tx_ready0, 1);

`ifdef SPI_LOOPBACK_EN
        s0_tx = 8'h00;
        lb_en = 1'b1;
        send(0, 8'h5A, 2'd0, 8'h5A, 8'h5A, 4'h1, 16);
        lb_en = 1'b0;
        wait_idle(0);
`endif

        repeat (5) @(negedge clk);
        for (int i = 0; i < 3; i++)
            check($sformatf("u%0d pending_expectations", i), q[i].size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
